// File: rtl/chess_pkg.sv
// Shared chess encodings: piece/colour codes, user states, changePiece fields
// and the packed initial board (square i at bits [4i+3:4i], address = {col, row}).
package chess_pkg;

    localparam logic [2:0] PIECE_EMPTY   = 3'd0;
    localparam logic [2:0] PIECE_PAWN    = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT  = 3'd2;
    localparam logic [2:0] PIECE_BISHOP  = 3'd3;
    localparam logic [2:0] PIECE_ROOK    = 3'd4;
    localparam logic [2:0] PIECE_QUEEN   = 3'd5;
    localparam logic [2:0] PIECE_KING    = 3'd6;
    localparam logic [2:0] PIECE_ILLEGAL = 3'd7;

    localparam logic COLOUR_WHITE = 1'b0;
    localparam logic COLOUR_BLACK = 1'b1;

    localparam logic [2:0] ST_START_GAME   = 3'b000;
    localparam logic [2:0] ST_IDLE         = 3'b001;
    localparam logic [2:0] ST_SELECT_PIECE = 3'b010;
    localparam logic [2:0] ST_SELECT_DEST  = 3'b011;
    localparam logic [2:0] ST_PLACE_PIECE  = 3'b100;

    localparam int unsigned CP_ADDR_LSB    = 0;
    localparam int unsigned CP_CONTENT_LSB = 6;
    localparam int unsigned CP_VALID_BIT   = 10;

    // One 32-bit word per column, row 7 in the top nibble, row 0 in the bottom.
    localparam logic [255:0] INIT_BOARD = {
        32'h4100_009C, 32'h2100_009A, 32'h3100_009B, 32'h6100_009E,
        32'h5100_009D, 32'h3100_009B, 32'h2100_009A, 32'h4100_009C
    };

    function automatic logic [2:0] piece_type(input logic [3:0] content);
        return content[2:0];
    endfunction

    function automatic logic piece_colour(input logic [3:0] content);
        return content[3];
    endfunction

endpackage

// File: rtl/capture_detect.sv
// Classifies a single-square write: capture of an opposing piece, king hit,
// or illegal new content.
module capture_detect
    import chess_pkg::*;
(
    input  logic [3:0] oldContent,
    input  logic [3:0] newContent,
    output logic       isCapture,
    output logic       capturedColour,
    output logic       isKing,
    output logic       isIllegal
);

    always_comb begin
        isIllegal      = (piece_type(newContent) == PIECE_ILLEGAL);
        capturedColour = piece_colour(oldContent);
        isKing         = (piece_type(oldContent) == PIECE_KING);
        isCapture      = !isIllegal
                         && (piece_type(newContent) != PIECE_EMPTY)
                         && (piece_type(oldContent) != PIECE_EMPTY)
                         && (piece_colour(oldContent) != piece_colour(newContent));
    end

endmodule

// File: rtl/board_store.sv
// Authoritative 64-square board: applies single-square writes and tracks
// captures, half-moves and game-over status.
module board_store
    import chess_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   currentState,
    input  logic [10:0]  changePiece,
    output logic [255:0] entireBoard,
    output logic [3:0]   capturedWhite,
    output logic [3:0]   capturedBlack,
    output logic [7:0]   moveCount,
    output logic         gameOver,
    output logic         winner,
    output logic         badWrite
);

    logic [3:0] board_q [64];
    logic [3:0] board_d [64];
    logic [3:0] cap_white_q, cap_white_d;
    logic [3:0] cap_black_q, cap_black_d;
    logic [7:0] move_count_q, move_count_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       bad_write_q, bad_write_d;

    logic [5:0] wr_addr;
    logic [3:0] wr_content;
    logic       wr_valid;
    logic [3:0] old_content;
    logic       is_capture, captured_colour, is_king, is_illegal;

    assign wr_addr     = changePiece[CP_ADDR_LSB +: 6];
    assign wr_content  = changePiece[CP_CONTENT_LSB +: 4];
    assign wr_valid    = changePiece[CP_VALID_BIT];
    assign old_content = board_q[wr_addr];

    capture_detect u_capture_detect (
        .oldContent     (old_content),
        .newContent     (wr_content),
        .isCapture      (is_capture),
        .capturedColour (captured_colour),
        .isKing         (is_king),
        .isIllegal      (is_illegal)
    );

    always_comb begin
        board_d      = board_q;
        cap_white_d  = cap_white_q;
        cap_black_d  = cap_black_q;
        move_count_d = move_count_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        bad_write_d  = bad_write_q;

        if (currentState == ST_START_GAME) begin
            for (int i = 0; i < 64; i++) begin
                board_d[i] = INIT_BOARD[4*i +: 4];
            end
            cap_white_d  = '0;
            cap_black_d  = '0;
            move_count_d = '0;
            game_over_d  = 1'b0;
            winner_d     = 1'b0;
            bad_write_d  = 1'b0;
        end else if (wr_valid && !game_over_q) begin
            if (is_illegal) begin
                bad_write_d = 1'b1;
            end else begin
                board_d[wr_addr] = wr_content;
                // Only the exact 0000 "remove" write marks a completed half-move.
                if (wr_content == 4'b0000) begin
                    move_count_d = move_count_q + 8'd1;
                end
                if (is_capture) begin
                    if (captured_colour == COLOUR_WHITE) begin
                        if (cap_white_q != 4'd15) cap_white_d = cap_white_q + 4'd1;
                    end else begin
                        if (cap_black_q != 4'd15) cap_black_d = cap_black_q + 4'd1;
                    end
                    if (is_king) begin
                        game_over_d = 1'b1;
                        winner_d    = piece_colour(wr_content);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                board_q[i] <= INIT_BOARD[4*i +: 4];
            end
            cap_white_q  <= '0;
            cap_black_q  <= '0;
            move_count_q <= '0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
            bad_write_q  <= 1'b0;
        end else begin
            board_q      <= board_d;
            cap_white_q  <= cap_white_d;
            cap_black_q  <= cap_black_d;
            move_count_q <= move_count_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            bad_write_q  <= bad_write_d;
        end
    end

    always_comb begin
        entireBoard = '0;
        for (int i = 0; i < 64; i++) begin
            entireBoard[4*i +: 4] = board_q[i];
        end
    end

    assign capturedWhite = cap_white_q;
    assign capturedBlack = cap_black_q;
    assign moveCount     = move_count_q;
    assign gameOver      = game_over_q;
    assign winner        = winner_q;
    assign badWrite      = bad_write_q;

endmodule

// File: tb/tb_board_store.sv
// Directed scenario bench for board_store; expectations are hand-derived.
module tb_board_store;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   currentState;
    logic [10:0]  changePiece;
    logic [255:0] entireBoard;
    logic [3:0]   capturedWhite, capturedBlack;
    logic [7:0]   moveCount;
    logic         gameOver, winner, badWrite;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] EXP_INIT = {
        32'h4100_009C, 32'h2100_009A, 32'h3100_009B, 32'h6100_009E,
        32'h5100_009D, 32'h3100_009B, 32'h2100_009A, 32'h4100_009C
    };

    board_store dut (
        .clk           (clk),
        .reset         (reset),
        .currentState  (currentState),
        .changePiece   (changePiece),
        .entireBoard   (entireBoard),
        .capturedWhite (capturedWhite),
        .capturedBlack (capturedBlack),
        .moveCount     (moveCount),
        .gameOver      (gameOver),
        .winner        (winner),
        .badWrite      (badWrite)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sq(input logic [5:0] addr);
        return entireBoard[4*addr +: 4];
    endfunction

    // Called at a negedge; applies one write across the next posedge.
    task automatic do_write(input logic [3:0] content, input logic [5:0] addr);
        changePiece = {1'b1, content, addr};
        @(negedge clk);
        changePiece = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        currentState = 3'b001;
        changePiece = {1'b1, 4'b0001, 6'h22};
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        changePiece = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (entireBoard !== EXP_INIT) begin errors++;
            $display("FAIL reset_board got %h want %h", entireBoard, EXP_INIT); end
        checks++; if (sq(6'h26) !== 4'b0001) begin errors++;
            $display("FAIL reset_sq26 got %b want 0001", sq(6'h26)); end
        checks++; if (sq(6'h27) !== 4'b0110) begin errors++;
            $display("FAIL reset_sq27 got %b want 0110", sq(6'h27)); end
        checks++; if (sq(6'h20) !== 4'b1110) begin errors++;
            $display("FAIL reset_sq20 got %b want 1110", sq(6'h20)); end
        checks++; if (sq(6'h22) !== 4'b0000) begin errors++;
            $display("FAIL reset_sq22 got %b want 0000", sq(6'h22)); end
        checks++; if ({capturedWhite, capturedBlack, moveCount, gameOver, winner, badWrite}
                      !== 19'd0) begin errors++;
            $display("FAIL reset_status got cw=%0d cb=%0d mc=%0d go=%b w=%b bw=%b want all 0",
                     capturedWhite, capturedBlack, moveCount, gameOver, winner, badWrite); end
    endtask

    task automatic test_back_to_back();
        do_write(4'b0001, 6'h24);
        do_write(4'b0000, 6'h26);
        checks++; if (sq(6'h24) !== 4'b0001) begin errors++;
            $display("FAIL move_dest got %b want 0001", sq(6'h24)); end
        checks++; if (sq(6'h26) !== 4'b0000) begin errors++;
            $display("FAIL move_src got %b want 0000", sq(6'h26)); end
        checks++; if (moveCount !== 8'd1) begin errors++;
            $display("FAIL move_count got %0d want 1", moveCount); end
        checks++; if ({capturedWhite, capturedBlack} !== 8'd0) begin errors++;
            $display("FAIL move_nocap got cw=%0d cb=%0d want 0 0", capturedWhite, capturedBlack); end
    endtask

    task automatic test_capture();
        // Black pawn onto the white knight at col 1 row 7.
        do_write(4'b1001, 6'h0F);
        checks++; if (capturedWhite !== 4'd1) begin errors++;
            $display("FAIL cap_white got %0d want 1", capturedWhite); end
        checks++; if (sq(6'h0F) !== 4'b1001) begin errors++;
            $display("FAIL cap_square got %b want 1001", sq(6'h0F)); end
        do_write(4'b1001, 6'h0F);
        checks++; if (capturedWhite !== 4'd1) begin errors++;
            $display("FAIL cap_repeat got %0d want 1", capturedWhite); end
        do_write(4'b0001, 6'h09);
        checks++; if (capturedBlack !== 4'd1) begin errors++;
            $display("FAIL cap_black got %0d want 1", capturedBlack); end
        do_write(4'b0011, 6'h0E);
        checks++; if ({capturedWhite, capturedBlack} !== {4'd1, 4'd1}) begin errors++;
            $display("FAIL cap_same_colour got cw=%0d cb=%0d want 1 1",
                     capturedWhite, capturedBlack); end
        checks++; if (gameOver !== 1'b0) begin errors++;
            $display("FAIL cap_no_gameover got %b want 0", gameOver); end
    endtask

    task automatic test_illegal();
        do_write(4'b0111, 6'h22);
        checks++; if (sq(6'h22) !== 4'b0000) begin errors++;
            $display("FAIL illegal_square got %b want 0000", sq(6'h22)); end
        checks++; if (badWrite !== 1'b1) begin errors++;
            $display("FAIL illegal_flag got %b want 1", badWrite); end
        do_write(4'b0011, 6'h22);
        checks++; if (sq(6'h22) !== 4'b0011) begin errors++;
            $display("FAIL illegal_next_square got %b want 0011", sq(6'h22)); end
        checks++; if (badWrite !== 1'b1) begin errors++;
            $display("FAIL illegal_sticky got %b want 1", badWrite); end
    endtask

    task automatic test_game_over();
        do_reset();
        do_write(4'b0101, 6'h20);
        checks++; if ({gameOver, winner} !== 2'b10) begin errors++;
            $display("FAIL king_white go=%b w=%b want 1 0", gameOver, winner); end
        checks++; if (capturedBlack !== 4'd1) begin errors++;
            $display("FAIL king_capcount got %0d want 1", capturedBlack); end
        do_write(4'b0001, 6'h00);
        do_write(4'b0111, 6'h01);
        checks++; if (sq(6'h00) !== 4'b1100) begin errors++;
            $display("FAIL frozen_square got %b want 1100", sq(6'h00)); end
        checks++; if (badWrite !== 1'b0) begin errors++;
            $display("FAIL frozen_badwrite got %b want 0", badWrite); end
        do_reset();
        do_write(4'b1101, 6'h27);
        checks++; if ({gameOver, winner, capturedWhite} !== {2'b11, 4'd1}) begin errors++;
            $display("FAIL king_black go=%b w=%b cw=%0d want 1 1 1",
                     gameOver, winner, capturedWhite); end
    endtask

    task automatic test_start_game();
        currentState = 3'b000;
        changePiece = {1'b1, 4'b0001, 6'h22};
        @(negedge clk);
        currentState = 3'b001;
        changePiece = '0;
        checks++; if (entireBoard !== EXP_INIT) begin errors++;
            $display("FAIL start_board got %h want %h", entireBoard, EXP_INIT); end
        checks++; if ({capturedWhite, capturedBlack, moveCount, gameOver, winner, badWrite}
                      !== 19'd0) begin errors++;
            $display("FAIL start_status got cw=%0d cb=%0d mc=%0d go=%b w=%b bw=%b want all 0",
                     capturedWhite, capturedBlack, moveCount, gameOver, winner, badWrite); end
    endtask

    task automatic test_saturate_wrap();
        for (int i = 0; i < 16; i++) begin
            do_write(4'b0001, 6'h21);
            do_write(4'b1001, 6'h21);
        end
        checks++; if ({capturedWhite, capturedBlack} !== {4'd15, 4'd15}) begin errors++;
            $display("FAIL saturate got cw=%0d cb=%0d want 15 15", capturedWhite, capturedBlack); end
        for (int i = 0; i < 255; i++) do_write(4'b0000, 6'h22);
        checks++; if (moveCount !== 8'd255) begin errors++;
            $display("FAIL move_255 got %0d want 255", moveCount); end
        do_write(4'b0000, 6'h22);
        do_write(4'b0000, 6'h22);
        checks++; if (moveCount !== 8'd1) begin errors++;
            $display("FAIL move_wrap got %0d want 1", moveCount); end
    endtask

    initial begin
        reset = 1'b1;
        currentState = 3'b001;
        changePiece = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_capture();
        test_illegal();
        test_game_over();
        test_start_game();
        test_saturate_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
